// File: rtl/score_event_writer_if.sv
// Single-bit write bus between score_event_writer and the 7-segment score display.
// The display returns its game-over flag on match_over.
interface score_event_writer_if;
    logic sel;
    logic addr;
    logic data_in;
    logic match_over;

    modport master (
        output sel,
        output addr,
        output data_in,
        input  match_over
    );

    modport slave (
        input  sel,
        input  addr,
        input  data_in,
        output match_over
    );
endinterface

// File: rtl/score_event_writer.sv
// Goal-edge event FIFO drained into the score display's one-bit write protocol.
// Define SCORE_EVENT_DROP_CNT_EN to build the saturating dropped-event counter.
module score_event_writer #(
    parameter int FIFO_DEPTH  = 4,
    parameter int GAP_CYCLES  = 2,
    parameter int OVER_CYCLES = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 goal_p1,
    input  logic                 goal_p2,
    score_event_writer_if.master dsp,
    output logic                 freeze,
    output logic                 score_clr,
    output logic [7:0]           drop_cnt
);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int PW   = AW + 1;
    localparam int CMAX = (OVER_CYCLES > GAP_CYCLES) ? OVER_CYCLES : GAP_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        GAP,
        OVER,
        CLEAR
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic            addr_r, addr_nxt;
    logic            goal_p1_q, goal_p2_q;
    logic            armed;
    logic [FIFO_DEPTH-1:0] mem;
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [PW-1:0]   wr_ptr_nxt, rd_ptr_nxt;
    logic [PW-1:0]   wr_ptr_p1, fill;
    logic [PW:0]     avail;
    logic            empty, pop, flush;
    logic            e1, e2, d0;
    logic [1:0]      n_push;

    assign fill  = wr_ptr - rd_ptr;
    assign empty = (fill == '0);
    assign pop   = (state == IDLE) && !dsp.match_over && !empty;

    // armed masks the first cycle after reset so a line held high gives no edge
    assign e1 = goal_p1 & ~goal_p1_q & ~freeze & armed;
    assign e2 = goal_p2 & ~goal_p2_q & ~freeze & armed;

    // the same-cycle pop frees its slot for this cycle's pushes
    assign avail = (PW+1)'(FIFO_DEPTH) - {1'b0, fill} + {{PW{1'b0}}, pop};

    always_comb begin
        n_push = 2'd0;
        unique case (1'b1)
            (e1 && e2): begin
                if (avail >= (PW+1)'(2))
                    n_push = 2'd2;
                else if (avail == (PW+1)'(1))
                    n_push = 2'd1;
                else
                    n_push = 2'd0;
            end
            (e1 ^ e2): n_push = (avail != '0) ? 2'd1 : 2'd0;
            default:   n_push = 2'd0;
        endcase
    end

    assign d0         = e1 ? 1'b0 : 1'b1;
    assign wr_ptr_p1  = wr_ptr + PW'(1);
    assign wr_ptr_nxt = wr_ptr + PW'(n_push);
    assign flush      = (state_nxt == OVER) && (state != OVER);
    assign rd_ptr_nxt = flush ? wr_ptr_nxt : rd_ptr + PW'(pop);
    assign addr_nxt   = pop ? mem[rd_ptr[AW-1:0]] : addr_r;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            IDLE: begin
                if (dsp.match_over) begin
                    state_nxt = OVER;
                    cnt_nxt   = CW'(OVER_CYCLES);
                end else if (!empty) begin
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                state_nxt = GAP;
                cnt_nxt   = CW'(GAP_CYCLES);
            end
            GAP: begin
                if (dsp.match_over) begin
                    state_nxt = OVER;
                    cnt_nxt   = CW'(OVER_CYCLES);
                end else if (cnt == CW'(1)) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            OVER: begin
                if (cnt == CW'(1)) begin
                    state_nxt = CLEAR;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            CLEAR: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            addr_r    <= 1'b0;
            goal_p1_q <= 1'b0;
            goal_p2_q <= 1'b0;
            armed     <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            addr_r    <= addr_nxt;
            goal_p1_q <= goal_p1;
            goal_p2_q <= goal_p2;
            armed     <= 1'b1;
            wr_ptr    <= wr_ptr_nxt;
            rd_ptr    <= rd_ptr_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (n_push != 2'd0)
            mem[wr_ptr[AW-1:0]] <= d0;
        if (n_push == 2'd2)
            mem[wr_ptr_p1[AW-1:0]] <= 1'b1;
    end

    assign dsp.sel     = (state == WRITE);
    assign dsp.data_in = (state == WRITE);
    assign dsp.addr    = addr_r;
    assign freeze      = (state == OVER) || (state == CLEAR);
    assign score_clr   = (state == CLEAR);

`ifdef SCORE_EVENT_DROP_CNT_EN
    logic [1:0] n_drop;
    logic [8:0] drop_sum;
    logic [7:0] drop_cnt_r;

    assign n_drop   = ({1'b0, e1} + {1'b0, e2}) - n_push;
    assign drop_sum = {1'b0, drop_cnt_r} + {7'd0, n_drop};

    always_ff @(posedge clk) begin
        if (rst || state == CLEAR)
            drop_cnt_r <= 8'd0;
        else
            drop_cnt_r <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end

    assign drop_cnt = drop_cnt_r;
`else
    assign drop_cnt = 8'd0;
`endif
endmodule

// File: tb/tb_score_event_writer.sv
// Randomized and directed bench for score_event_writer against an
// event-schedule reference model (queue plus predicted strobe/gap/freeze windows).
module tb_score_event_writer;
    localparam int DEPTH = 4;
    localparam int GAP   = 2;
    localparam int OVER  = 20;

    logic       clk = 1'b0;
    logic       rst;
    logic       goal_p1, goal_p2;
    logic       freeze, score_clr;
    logic [7:0] drop_cnt;

    score_event_writer_if bus ();

    score_event_writer #(
        .FIFO_DEPTH (DEPTH),
        .GAP_CYCLES (GAP),
        .OVER_CYCLES(OVER)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .goal_p1  (goal_p1),
        .goal_p2  (goal_p2),
        .dsp      (bus),
        .freeze   (freeze),
        .score_clr(score_clr),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int n_sel = 0;
    int n_clr = 0;
    int last_sel_cyc = -1;
    int last_clr_cyc = -1;

    // reference model: pending events and predicted output windows
    int q[$];
    int strobe_at, addr_exp, gap_lo, gap_hi, ready_at;
    int frz_lo, frz_hi, clr_at, drops, arm_at;
    bit p1_prev, p2_prev;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
        end
    endtask

    function automatic void m_reset(input int c);
        q.delete();
        strobe_at = -1;
        addr_exp  = 0;
        gap_lo    = -1;
        gap_hi    = -1;
        ready_at  = c + 1;
        frz_lo    = -1;
        frz_hi    = -1;
        clr_at    = -1;
        drops     = 0;
        arm_at    = c + 2;
        p1_prev   = 1'b0;
        p2_prev   = 1'b0;
    endfunction

    function automatic void m_step(input int c, input bit g1, input bit g2,
                                   input bit mo, input bit r);
        bit frz, e1, e2, idle, in_gap, go_over, popped;
        int head, free;
        if (r) begin
            m_reset(c);
            return;
        end
        frz    = (c >= frz_lo) && (c <= frz_hi);
        e1     = g1 && !p1_prev && !frz && (c >= arm_at);
        e2     = g2 && !p2_prev && !frz && (c >= arm_at);
        p1_prev = g1;
        p2_prev = g2;
        idle    = !frz && (c >= ready_at);
        in_gap  = (c >= gap_lo) && (c <= gap_hi);
        go_over = (idle || in_gap) && mo;
        popped  = idle && !mo && (q.size() > 0);
        head    = 0;
        if (popped)
            head = q.pop_front();
        free = DEPTH - q.size();
        if (e1) begin
            if (free > 0) begin
                q.push_back(0);
                free--;
            end else drops++;
        end
        if (e2) begin
            if (free > 0) begin
                q.push_back(1);
                free--;
            end else drops++;
        end
        if (drops > 255)
            drops = 255;
        if (go_over) begin
            q.delete();
            frz_lo   = c + 1;
            frz_hi   = c + OVER + 1;
            clr_at   = c + OVER + 1;
            ready_at = c + OVER + 2;
            gap_lo   = -1;
            gap_hi   = -1;
        end
        if (popped) begin
            strobe_at = c + 1;
            addr_exp  = head;
            gap_lo    = c + 2;
            gap_hi    = c + 1 + GAP;
            ready_at  = c + 2 + GAP;
        end
        if (c == clr_at)
            drops = 0;
    endfunction

    task automatic step(input bit g1, input bit g2, input bit mo, input bit r);
        int exp_drop;
        goal_p1        = g1;
        goal_p2        = g2;
        bus.match_over = mo;
        rst            = r;
`ifdef SCORE_EVENT_DROP_CNT_EN
        exp_drop = drops;
`else
        exp_drop = 0;
`endif
        check("sel", 32'(bus.sel), 32'(cyc == strobe_at));
        check("data_in", 32'(bus.data_in), 32'(cyc == strobe_at));
        check("addr", 32'(bus.addr), 32'(addr_exp));
        check("freeze", 32'(freeze), 32'(cyc >= frz_lo && cyc <= frz_hi));
        check("score_clr", 32'(score_clr), 32'(cyc == clr_at));
        check("drop_cnt", 32'(drop_cnt), 32'(exp_drop));
        if (bus.sel === 1'b1) begin
            n_sel++;
            last_sel_cyc = cyc;
        end
        if (score_clr === 1'b1) begin
            n_clr++;
            last_clr_cyc = cyc;
        end
        m_step(cyc, g1, g2, mo, r);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        int t0, s0, c0, mo_cyc, k;
        rst            = 1'b1;
        goal_p1        = 1'b0;
        goal_p2        = 1'b0;
        bus.match_over = 1'b0;
        @(posedge clk);
        #1;
        m_reset(-1);

        // single p1 pulse, strobe two cycles later
        do_reset();
        while (cyc < 10)
            step(1'b0, 1'b0, 1'b0, 1'b0);
        t0 = cyc;
        s0 = n_sel;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        idle(12);
        check("single_cnt", 32'(n_sel - s0), 32'd1);
        check("single_lat", 32'(last_sel_cyc), 32'(t0 + 2));

        // both players in the same cycle
        do_reset();
        idle(2);
        s0 = n_sel;
        step(1'b1, 1'b1, 1'b0, 1'b0);
        idle(14);
        check("dual_cnt", 32'(n_sel - s0), 32'd2);
        check("dual_last_addr", 32'(bus.addr), 32'd1);

        // six p2 edges two cycles apart
        do_reset();
        idle(2);
        s0 = n_sel;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0);
            step(1'b0, 1'b0, 1'b0, 1'b0);
        end
        idle(30);
        check("burst_min", 32'(n_sel - s0 >= 4), 32'd1);
`ifdef SCORE_EVENT_DROP_CNT_EN
        check("burst_total", 32'(n_sel - s0 + int'(drop_cnt)), 32'd6);
`endif

        // match over during gap with two events queued
        do_reset();
        idle(2);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        k = 0;
        while (!(cyc >= gap_lo && cyc <= gap_hi) && k < 20) begin
            step(1'b0, 1'b0, 1'b0, 1'b0);
            k++;
        end
        check("gap_reached", 32'(k < 20), 32'd1);
        check("gap_queued", 32'(q.size()), 32'd2);
        s0 = n_sel;
        c0 = n_clr;
        mo_cyc = cyc;
        step(1'b0, 1'b0, 1'b1, 1'b0);
        idle(OVER + 8);
        check("over_strobes", 32'(n_sel - s0), 32'd0);
        check("over_clr_cnt", 32'(n_clr - c0), 32'd1);
        check("over_clr_cyc", 32'(last_clr_cyc), 32'(mo_cyc + OVER + 1));

        // line held high through reset
        step(1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        s0 = n_sel;
        for (int i = 0; i < 8; i++)
            step(1'b1, 1'b0, 1'b0, 1'b0);
        check("held_none", 32'(n_sel - s0), 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        idle(10);
        check("held_rise", 32'(n_sel - s0), 32'd1);

        // reset in the write cycle
        do_reset();
        idle(2);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        k = 0;
        while (cyc != strobe_at && k < 10) begin
            step(1'b0, 1'b0, 1'b0, 1'b0);
            k++;
        end
        check("write_reached", 32'(k < 10), 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        s0 = n_sel;
        idle(12);
        check("rst_write_none", 32'(n_sel - s0), 32'd0);

        // random traffic
        do_reset();
        for (int i = 0; i < 4000; i++)
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 199) == 0),
                 1'($urandom_range(0, 599) == 0));
        idle(OVER + 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
